mult_div_unit: RTL and testbench

//   Iterative MIPS multiply/divide unit owning the HI/LO registers. Sits directly downstream of

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_step.sv | 46 ++++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MDU_WIDTH : default operand / HI / LO width (also the iteration count)
//   - MDU_*     : 3-bit operation codes presented on the op port
//   - mdu_state_e : control FSM states
//   - op_is_* helpers : decode of the op field used by the top level
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;
  localparam logic [2:0] MDU_NOP   = 3'b110;  // 3'b111 is also a NOP

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU are the only multi-cycle operations (op[2] == 0).
  function automatic logic op_is_iter(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // MULT and DIV are the signed variants (even codes below 4).
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
//   is_div   in   1      0: shift-add multiply step, 1: restoring divide step
//   acc_hi   in   WIDTH  multiply: partial product upper half / divide: partial remainder
//   acc_lo   in   WIDTH  multiply: remaining multiplier bits / divide: dividend bits, quotient shifted in
//   operand  in   WIDTH  multiplicand (multiply) or divisor (divide), magnitudes only
//   next_hi  out  WIDTH  acc_hi after this iteration
//   next_lo  out  WIDTH  acc_lo after this iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;      // multiply: carry + upper half
  logic [WIDTH:0]   shifted;  // divide: remainder with next dividend bit appended
  logic [WIDTH-1:0] diff;
  logic             fits;

  // NOTE: every output and temporary gets a value on every path through this
  // block, so no latches are inferred.
  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift {carry, hi, lo} right by one; the product fills in from the top.
    sum = {1'b0, acc_hi} + {1'b0, operand & {WIDTH{acc_lo[0]}}};

    // Divide: the partial remainder is always below the divisor, so the
    // shifted value is below 2*divisor and the subtraction fits in WIDTH bits.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    diff    = shifted[WIDTH-1:0] - operand;

    if (is_div) begin
      next_hi = fits ? diff : shifted[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
//   clock        in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request, sampled only while idle
//   op           in   3      operation code (mdu_pkg MDU_*)
//   in_s1        in   WIDTH  rs: dividend / multiplicand / MTHI-MTLO source
//   in_s2        in   WIDTH  rt: divisor / multiplier
//   busy         out  1      multiply or divide in flight
//   done         out  1      one-cycle pulse, hi/lo valid in the same cycle
//   div_by_zero  out  1      pulses with done for a DIV/DIVU with zero divisor
//   hi, lo       out  WIDTH  HI and LO registers
// Operations run on magnitudes for WIDTH cycles, then a FINISH cycle applies
// the sign fixup and writes HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] in_s2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e       state_q, state_d;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] dividend_q, dividend_d;  // raw in_s1, returned in HI on divide by zero
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;      // negate product / quotient
  logic             neg_hi_q, neg_hi_d;      // negate remainder
  logic             zero_div_q, zero_div_d;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] step_hi, step_lo;
  logic             sgn1, sgn2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [2*WIDTH-1:0] product;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Operand signs only matter for MULT/DIV; unsigned ops use the raw values.
  // The magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign sgn1    = op_is_signed(op) & in_s1[WIDTH-1];
  assign sgn2    = op_is_signed(op) & in_s2[WIDTH-1];
  assign mag1    = sgn1 ? -in_s1 : in_s1;
  assign mag2    = sgn2 ? -in_s2 : in_s2;
  assign product = {acc_hi_q, acc_lo_q};

  // State register and architectural state carry the synchronous reset.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // NOTE: the iteration datapath has no reset; it is always loaded on the
  // accepting edge before any of it is used, and the FSM reset alone aborts
  // an operation.
  always_ff @(posedge clock) begin
    count_q    <= count_d;
    acc_hi_q   <= acc_hi_d;
    acc_lo_q   <= acc_lo_d;
    operand_q  <= operand_d;
    dividend_q <= dividend_d;
    is_div_q   <= is_div_d;
    neg_lo_q   <= neg_lo_d;
    neg_hi_q   <= neg_hi_d;
    zero_div_q <= zero_div_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start && op_is_iter(op)) state_d = ST_RUN;
      ST_RUN:    if (count_q == '0)           state_d = ST_FINISH;
      ST_FINISH:                              state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    count_d       = count_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    operand_d     = operand_q;
    dividend_d    = dividend_q;
    is_div_d      = is_div_q;
    neg_lo_d      = neg_lo_q;
    neg_hi_d      = neg_hi_q;
    zero_div_d    = zero_div_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && op_is_iter(op)) begin
          count_d    = CW'(WIDTH - 1);
          is_div_d   = op_is_div(op);
          neg_lo_d   = sgn1 ^ sgn2;
          neg_hi_d   = sgn1;
          zero_div_d = (in_s2 == '0);
          dividend_d = in_s1;
          acc_hi_d   = '0;
          // Multiply shifts the multiplier out of LO; divide shifts the
          // dividend out of LO while the quotient shifts in behind it.
          acc_lo_d   = op_is_div(op) ? mag1 : mag2;
          operand_d  = op_is_div(op) ? mag2 : mag1;
        end else if (start && op == MDU_MTHI) begin
          hi_d = in_s1;
        end else if (start && op == MDU_MTLO) begin
          lo_d = in_s1;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q - CW'(1);
      end
      ST_FINISH: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_lo_q ? -product : product;
        end else if (zero_div_q) begin
          hi_d          = dividend_q;
          lo_d          = '1;
          div_by_zero_d = 1'b1;
        end else begin
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH = 32): fixed vector table,
// hand-written multi-cycle sequences, then randomized operations compared
// against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // start edge to done edge

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] in_s1, in_s2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .in_s1       (in_s1),
    .in_s2       (in_s2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: returns {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT: begin
        p = sa * sb;
        return {1'b0, p};
      end
      OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        return {1'b0, u};
      end
      OP_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;   // truncating; remainder takes the dividend's sign
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue one multiply/divide, change the inputs after acceptance, and wait
  // for done. Leaves the caller in the done cycle (#1 after that edge).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    int lat;
    int busy_n;
    start = 1'b1; op = o; in_s1 = a; in_s2 = b;
    @(posedge clock); #1;
    start = 1'b0; in_s1 = $urandom; in_s2 = $urandom;
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    check({tag, "_done_low_after_accept"}, 64'(done), 64'd0);
    lat = 0; busy_n = 0;
    while (lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (done) break;
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    rh = hi; rl = lo; rz = div_by_zero;
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; in_s1 = v; in_s2 = $urandom;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return corners[$urandom_range(0, 4)];
      default: return -32'($urandom_range(1, 20));
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rh, rl, mh, ml;
    logic        rz;
    logic [64:0] m;
    logic [2:0]  o;
    logic [31:0] a, b, v;
    int          cnt, bcnt, lat;

    vecs[0] = '{"multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{"mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{"div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{"divu_100d7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{"divu_by0",    OP_DIVU,  32'h64,        32'd0,         32'h64,        32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{"div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[6] = '{"mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
    vecs[7] = '{"div_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{"div_0by0",    OP_DIV,   32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{"mult_m1x1",   OP_MULT,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = 3'b110; in_s1 = '0; in_s2 = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz",  64'(div_by_zero), 64'd0);
    check("reset_hi",   64'(hi), 64'd0);
    check("reset_lo",   64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Fixed vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rz);
      check($sformatf("%s_hi", vecs[i].name),  64'(rh), 64'(vecs[i].hi));
      check($sformatf("%s_lo", vecs[i].name),  64'(rl), 64'(vecs[i].lo));
      check($sformatf("%s_dbz", vecs[i].name), 64'(rz), 64'(vecs[i].dbz));
      @(posedge clock); #1;
      check($sformatf("%s_done_one_cycle", vecs[i].name), 64'(done), 64'd0);
      check($sformatf("%s_dbz_one_cycle", vecs[i].name),  64'(div_by_zero), 64'd0);
    end

    // MTHI then MTLO on consecutive edges.
    do_mt(OP_MTHI, 32'h1234);
    check("mthi_hi",   64'(hi), 64'h1234);
    check("mthi_done", 64'(done), 64'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    do_mt(OP_MTLO, 32'hABCD);
    check("mtlo_lo",   64'(lo), 64'hABCD);
    check("mtlo_hi",   64'(hi), 64'h1234);
    check("mtlo_done", 64'(done), 64'd0);

    // Requests while busy are ignored, MTHI included.
    start = 1'b1; op = OP_MULTU; in_s1 = 32'd7; in_s2 = 32'd9;
    @(posedge clock); #1;
    lat = 0;
    while (lat < 100) begin
      if (lat == 3) begin
        start = 1'b1; op = OP_MULTU; in_s1 = 32'd2; in_s2 = 32'd3;
      end else if (lat == 4) begin
        start = 1'b1; op = OP_MTHI; in_s1 = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
    check("ignore_latency", 64'(lat), 64'(LAT));
    check("ignore_lo", 64'(lo), 64'd63);
    check("ignore_hi", 64'(hi), 64'd0);
    cnt = 0; bcnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) cnt++;
      if (busy) bcnt++;
    end
    check("ignore_no_second_done", 64'(cnt), 64'd0);
    check("ignore_no_busy_ext",    64'(bcnt), 64'd0);
    check("ignore_lo_held",        64'(lo), 64'd63);

    // Reset mid-operation aborts with no done pulse.
    do_mt(OP_MTHI, 32'h55);
    start = 1'b1; op = OP_MULT; in_s1 = 32'd5; in_s2 = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_hi_old", 64'(hi), 64'h55);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi",   64'(hi), 64'd0);
    check("abort_lo",   64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    run_op("after_abort", OP_MULTU, 32'd6, 32'd7, rh, rl, rz);
    check("after_abort_lo", 64'(rl), 64'd42);
    check("after_abort_hi", 64'(rh), 64'd0);

    // New start accepted in the done cycle.
    run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, rh, rl, rz);
    check("b2b_first_lo", 64'(rl), 64'd14);
    run_op("b2b_second", OP_MULTU, 32'h0001_0000, 32'h0001_0000, rh, rl, rz);
    check("b2b_second_hi", 64'(rh), 64'd1);
    check("b2b_second_lo", 64'(rl), 64'd0);
    @(posedge clock); #1;

    // Randomized operations against the reference model.
    mh = $urandom; ml = $urandom;
    do_mt(OP_MTHI, mh);
    do_mt(OP_MTLO, ml);
    check("rand_init_hi", 64'(hi), 64'(mh));
    check("rand_init_lo", 64'(lo), 64'(ml));
    for (int i = 0; i < 50; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      if (o <= OP_DIVU) begin
        m = model(o, a, b);
        run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, rh, rl, rz);
        check($sformatf("rand%0d_hi a=%h b=%h op=%0d", i, a, b, o), 64'(rh), 64'(m[63:32]));
        check($sformatf("rand%0d_lo a=%h b=%h op=%0d", i, a, b, o), 64'(rl), 64'(m[31:0]));
        check($sformatf("rand%0d_dbz", i), 64'(rz), 64'(m[64]));
        mh = m[63:32]; ml = m[31:0];
      end else if (o == OP_MTHI || o == OP_MTLO) begin
        v = $urandom;
        do_mt(o, v);
        if (o == OP_MTHI) mh = v; else ml = v;
        check($sformatf("rand%0d_mt_hi", i), 64'(hi), 64'(mh));
        check($sformatf("rand%0d_mt_lo", i), 64'(lo), 64'(ml));
        check($sformatf("rand%0d_mt_done", i), 64'(done), 64'd0);
      end else begin
        do_mt(o, a);
        check($sformatf("rand%0d_nop_busy", i), 64'(busy), 64'd0);
        check($sformatf("rand%0d_nop_hi", i), 64'(hi), 64'(mh));
        check($sformatf("rand%0d_nop_lo", i), 64'(lo), 64'(ml));
      end
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
